// File: rtl/ps2_keyboard_rx_pkg.sv
// ps2_keyboard_rx shared types
// FSM states, prefix codes and the scan code type
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  typedef logic [7:0] scan_t;

  localparam scan_t PS2_BREAK_PREFIX = 8'hF0;
  localparam scan_t PS2_EXT_PREFIX   = 8'hE0;

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// ps2_keyboard_rx key event bundle
// master = receiver, slave = scan-code decoder
interface ps2_keyboard_rx_if;
  import ps2_pkg::*;

  scan_t scan_code;
  logic  code_valid;
  logic  is_break;
  logic  is_extended;
  logic  frame_error;
  logic  rx_busy;

  modport master (
    output scan_code,
    output code_valid,
    output is_break,
    output is_extended,
    output frame_error,
    output rx_busy
  );

  modport slave (
    input scan_code,
    input code_valid,
    input is_break,
    input is_extended,
    input frame_error,
    input rx_busy
  );

endinterface

// File: rtl/ps2_keyboard_rx_filter.sv
// ps2_keyboard_rx pin synchroniser and clock de-glitch
// filt_clk flips after FILTER_LEN equal differing samples
module ps2_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic data_sync_o,
  output logic filt_clk_o,
  output logic fall_evt_o
);
  import ps2_pkg::*;

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   filt_q;
  logic                   filt_d;
  logic                   fall_q;
  logic                   fall_d;
  logic                   clk_s;

  assign clk_s = clk_sync_q[SYNC_STAGES-1];

  // Next filtered level: flip on the FILTER_LEN-th differing sample
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    fall_d = 1'b0;
    if (clk_s != filt_q) begin
      if (cnt_q == LAST) begin
        filt_d = clk_s;
        fall_d = ~clk_s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Pin synchronisers and filter state, idle-high out of reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      cnt_q      <= '0;
      filt_q     <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      cnt_q      <= cnt_d;
      filt_q     <= filt_d;
      fall_q     <= fall_d;
    end
  end

  assign data_sync_o = dat_sync_q[SYNC_STAGES-1];
  assign filt_clk_o  = filt_q;
  assign fall_evt_o  = fall_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 Set 2 device-to-host receiver
// Deserialises frames and folds E0/F0 prefixes into flags
module ps2_keyboard_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_keyboard_rx_if.master evt
);
  import ps2_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    rst_sync_q;
  logic          rst_int_n;
  logic          data_s;
  logic          filt_clk;
  logic          fall_evt;
  logic          fall;
  state_t        state_q;
  logic [2:0]    bit_cnt_q;
  scan_t         shift_q;
  logic          par_q;
  logic [TW-1:0] to_q;
  logic          brk_pend_q;
  logic          ext_pend_q;
  scan_t         scan_q;
  logic          valid_q;
  logic          brk_q;
  logic          ext_q;
  logic          err_q;
  logic          good;

  // Async assert, sync deassert of the internal reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  ps2_input_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_filter (
    .clk_i       (clk),
    .rst_ni      (rst_int_n),
    .ps2_clk_i   (ps2_clk),
    .ps2_data_i  (ps2_data),
    .data_sync_o (data_s),
    .filt_clk_o  (filt_clk),
    .fall_evt_o  (fall_evt)
  );

  // Edge is only honoured once the filtered level is really low
  assign fall = fall_evt & ~filt_clk;
  assign good = data_s & (^shift_q ^ par_q);

  // Frame FSM, prefix folding, timeout and registered outputs
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      to_q       <= '0;
      brk_pend_q <= 1'b0;
      ext_pend_q <= 1'b0;
      scan_q     <= '0;
      valid_q    <= 1'b0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (state_q == IDLE || fall) to_q <= '0;
      else                         to_q <= to_q + 1'b1;
      if (fall) begin
        unique case (state_q)
          IDLE: begin
            if (!data_s) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end
          end
          DATA: begin
            shift_q[bit_cnt_q] <= data_s;
            bit_cnt_q          <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= data_s;
            state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (good) begin
              unique case (1'b1)
                (shift_q == PS2_BREAK_PREFIX): brk_pend_q <= 1'b1;
                (shift_q == PS2_EXT_PREFIX):   ext_pend_q <= 1'b1;
                default: begin
                  scan_q     <= shift_q;
                  brk_q      <= brk_pend_q;
                  ext_q      <= ext_pend_q;
                  valid_q    <= 1'b1;
                  brk_pend_q <= 1'b0;
                  ext_pend_q <= 1'b0;
                end
              endcase
            end else begin
              err_q      <= 1'b1;
              brk_pend_q <= 1'b0;
              ext_pend_q <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q != IDLE && to_q == TO_LAST) begin
        state_q    <= IDLE;
        err_q      <= 1'b1;
        brk_pend_q <= 1'b0;
        ext_pend_q <= 1'b0;
      end
    end
  end

  assign evt.scan_code   = scan_q;
  assign evt.code_valid  = valid_q;
  assign evt.is_break    = brk_q;
  assign evt.is_extended = ext_q;
  assign evt.frame_error = err_q;
  assign evt.rx_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// ps2_keyboard_rx directed testbench
// Drives PS/2 frames on the pins and checks decoded events
module tb_ps2_keyboard_rx;

  localparam int H  = 30;
  localparam int TO = 400;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;

  int n_chk  = 0;
  int n_err  = 0;
  int nvalid = 0;
  int nferr  = 0;
  int nboth  = 0;
  int v0;
  int e0;

  always #5 clk = ~clk;

  ps2_keyboard_rx_if rx_if ();

  ps2_keyboard_rx #(
    .SYNC_STAGES    (2),
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .evt      (rx_if)
  );

  always @(negedge clk) begin
    if (rx_if.code_valid) nvalid++;
    if (rx_if.frame_error) nferr++;
    if (rx_if.code_valid && rx_if.frame_error) nboth++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b,
                           input bit flip,
                           input int nbits,
                           input int glen,
                           input int gbit);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      if (glen > 0 && i == gbit) begin
        wait_clk(12);
        ps2_clk = 1'b0;
        wait_clk(glen);
        ps2_clk = 1'b1;
        wait_clk(H - 12 - glen);
      end else begin
        wait_clk(H);
      end
      ps2_clk = 1'b0;
      wait_clk(H);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input bit flip,
                            input int glen,
                            input int gbit);
    send_bits(b, flip, 11, glen, gbit);
    ps2_data = 1'b1;
    wait_clk(H);
  endtask

  initial begin
    wait_clk(3);
    chk("rst_scan", {24'd0, rx_if.scan_code}, 32'h00);
    chk("rst_valid", {31'd0, rx_if.code_valid}, 0);
    chk("rst_busy", {31'd0, rx_if.rx_busy}, 0);
    chk("rst_flags", {30'd0, rx_if.is_break, rx_if.is_extended}, 0);
    rst_n = 1'b1;
    wait_clk(10);

    // single make code
    v0 = nvalid; e0 = nferr;
    send_frame(8'h16, 1'b0, 0, 0);
    chk("t1_nvalid", nvalid - v0, 1);
    chk("t1_scan", {24'd0, rx_if.scan_code}, 32'h16);
    chk("t1_flags", {30'd0, rx_if.is_break, rx_if.is_extended}, 0);
    chk("t1_nerr", nferr - e0, 0);

    // break and extended-break sequences
    v0 = nvalid;
    send_frame(8'hF0, 1'b0, 0, 0);
    send_frame(8'h16, 1'b0, 0, 0);
    chk("t2a_nvalid", nvalid - v0, 1);
    chk("t2a_scan", {24'd0, rx_if.scan_code}, 32'h16);
    chk("t2a_flags", {30'd0, rx_if.is_break, rx_if.is_extended}, 32'h2);
    v0 = nvalid;
    send_frame(8'hE0, 1'b0, 0, 0);
    send_frame(8'hF0, 1'b0, 0, 0);
    send_frame(8'h75, 1'b0, 0, 0);
    chk("t2b_nvalid", nvalid - v0, 1);
    chk("t2b_scan", {24'd0, rx_if.scan_code}, 32'h75);
    chk("t2b_flags", {30'd0, rx_if.is_break, rx_if.is_extended}, 32'h3);

    // parity error after a pending break prefix
    v0 = nvalid; e0 = nferr;
    send_frame(8'hF0, 1'b0, 0, 0);
    send_frame(8'h1C, 1'b1, 0, 0);
    chk("t3_nerr", nferr - e0, 1);
    chk("t3_nvalid", nvalid - v0, 0);
    chk("t3_scan_hold", {24'd0, rx_if.scan_code}, 32'h75);
    chk("t3_brk_hold", {31'd0, rx_if.is_break}, 1);
    send_frame(8'h45, 1'b0, 0, 0);
    chk("t3_scan_next", {24'd0, rx_if.scan_code}, 32'h45);
    chk("t3_flags_next", {30'd0, rx_if.is_break, rx_if.is_extended}, 0);

    // partial frame resolved by timeout
    e0 = nferr; v0 = nvalid;
    send_bits(8'h33, 1'b0, 5, 0, 0);
    wait_clk(5);
    chk("t4_busy", {31'd0, rx_if.rx_busy}, 1);
    wait_clk(TO + 50);
    chk("t4_nerr", nferr - e0, 1);
    chk("t4_idle", {31'd0, rx_if.rx_busy}, 0);
    send_frame(8'h5A, 1'b0, 0, 0);
    chk("t4_scan", {24'd0, rx_if.scan_code}, 32'h5A);
    chk("t4_nvalid", nvalid - v0, 1);

    // short glitch ignored, full-length glitch misaligns
    v0 = nvalid; e0 = nferr;
    send_frame(8'h29, 1'b0, 7, 3);
    chk("t5s_nvalid", nvalid - v0, 1);
    chk("t5s_scan", {24'd0, rx_if.scan_code}, 32'h29);
    chk("t5s_nerr", nferr - e0, 0);
    v0 = nvalid; e0 = nferr;
    send_frame(8'h29, 1'b0, 8, 1);
    wait_clk(TO + 50);
    chk("t5l_nvalid", nvalid - v0, 0);
    chk("t5l_err", {31'd0, (nferr - e0) >= 1}, 1);
    chk("t5l_idle", {31'd0, rx_if.rx_busy}, 0);

    // async reset mid-frame
    e0 = nferr;
    send_bits(8'h66, 1'b0, 7, 0, 0);
    wait_clk(5);
    chk("t6_busy", {31'd0, rx_if.rx_busy}, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_scan_rst", {24'd0, rx_if.scan_code}, 32'h00);
    chk("t6_busy_rst", {31'd0, rx_if.rx_busy}, 0);
    wait_clk(5);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(10);
    chk("t6_noerr", nferr - e0, 0);
    v0 = nvalid;
    send_frame(8'h26, 1'b0, 0, 0);
    chk("t6_scan", {24'd0, rx_if.scan_code}, 32'h26);
    chk("t6_nvalid", nvalid - v0, 1);

    chk("never_both", nboth, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
